ps2_key_rx: RTL and testbench
=============================

# ps2_key_rx

PS/2 keyboard receiver feeding the CPC `hid` keyboard matrix. It deserialises 11-bit PS/2 device frames and folds the Set-2 prefixes (E0, F0, E1) into one key event. Each event goes out on the 11-bit toggle-strobed `ps2_key` bus that `hid` consumes. Host-to-device transmission is out of scope; the block only listens.

## Interface
- `FILTER_LEN`, 8: consecutive equal samples needed before the filtered PS/2 clock changes level (2..255).
- `TIMEOUT_CYC`, 12000: `clk` cycles allowed between falling edges inside a frame before the frame is aborted.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock line; asynchronous.
- `ps2_data`  in  1  raw PS/2 data line; asynchronous.
- `ps2_key`  out  11  bit 10 toggles once per event; bit 9 is 1 for make, 0 for break; bit 8 is the extended (E0) flag; bits 7:0 are the scan code.
- `err`  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- Both inputs pass through a 2-FF synchroniser.
- Filtering applies to `ps2_clk` only. A counter reloads whenever the synchronised sample equals the filtered level. When the sample differs for FILTER_LEN consecutive cycles, the filtered level flips.
- A falling edge of the filtered clock produces a one-cycle `fall` strobe.
- On every `fall`, the synchronised data bit is sampled.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data 0, go to DATA and clear the bit counter. A start bit of 1 is ignored; the FSM stays in IDLE and `err` does not pulse.
  - DATA: shift in 8 bits, LSB first. After the 8th bit, go to PARITY.
  - PARITY: the sampled bit must make the count of ones across the 8 data bits plus parity odd. Record pass or fail, then go to STOP.
  - STOP: the sampled bit must be 1. If it is 1 and parity passed, the byte is valid; otherwise pulse `err`. Return to IDLE in either case.
- Timeout: in any state other than IDLE, a counter of cycles since the last `fall` runs. When it reaches TIMEOUT_CYC: go to IDLE, pulse `err`, clear all prefix state.
- Valid-byte handling, in priority order:
  1. If `skip` is non-zero, decrement it and drop the byte.
  2. E1: set `skip`=7 and drop the byte (consumes the Pause sequence).
  3. E0: set `ext` and drop the byte.
  4. F0: set `rel` and drop the byte.
  5. 00, AA, EE, FA, FE, FF: drop the byte and clear `ext` and `rel`.
  6. 12 or 59 with `ext` set (fake shifts): drop the byte and clear the flags.
  7. Any other byte: `ps2_key` <= {~ps2_key[10], ~rel, ext, byte}, then clear `ext` and `rel`.
- Byte errors (parity or stop) also clear `ext`, `rel` and `skip`.
- Reset, asynchronous and taking effect mid-frame too:
  - `ps2_key` = 0 and `err` = 0.
  - FSM goes to IDLE with all counters, prefix flags and `skip` cleared.
  - The filtered clock level and synchroniser flops go to 1 (the idle bus level).

## Timing
- From a falling edge of `ps2_clk` at the pin to `fall`: exactly FILTER_LEN+3 `clk` cycles, given clean input (2 synchroniser cycles, FILTER_LEN filter cycles, 1 edge-detect cycle).
- `ps2_key` is registered: it changes on the `clk` edge after the `fall` that samples the stop bit, i.e. FILTER_LEN+4 cycles after the 11th pin falling edge.
- `err` pulses for exactly one cycle, on that same edge.
- `ps2_key` is stable between events. Bits 9:0 and bit 10 change in the same cycle.
- The downstream block detects events only by the bit-10 toggle. Events are at least one frame apart, so no back-pressure is needed.
- Timeout is measured from the cycle of the last `fall`. The abort takes effect on the cycle the count equals TIMEOUT_CYC.
- If a `fall` and the timeout occur in the same cycle, the `fall` wins and the counter reloads.

## Structure
- Package `ps2_pkg` holds the FSM state enum and localparams for the special codes: E0, E1, F0, AA, EE, FA, FE, 00, FF, and the fake-shift codes 12 and 59.
- One sub-module, `ps2_line_filter`: 2-FF synchroniser plus the FILTER_LEN glitch filter. It outputs the filtered level and the `fall` strobe.
- The FSM, parity check, prefix logic and timeout live in the top level.

## Test plan
- Frame for 1C (start 0, data LSB first, parity 0, stop 1) at a 60 µs bit period -> `ps2_key` = {1,1,0,1C}; no `err`.
- Sequence E0 F0 75 after that event -> one event only, `ps2_key` = {0,0,1,75}; the prefixes produce no events.
- 1C frame with the parity bit flipped, followed by a good 1C frame -> one `err` pulse, then a single event {~t,1,0,1C}, where t is the bit-10 value before the good frame.
- Abandon a frame after 5 bits and wait TIMEOUT_CYC+10 cycles, then send 29 -> `err` pulses at the exact timeout cycle, and 29 decodes correctly.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then E0 12, then AA, then 16 -> only 16 is emitted, as {t',1,0,16}; glitches shorter than FILTER_LEN cycles on `ps2_clk` during the frames are ignored.
- Assert `reset_n` after the 6th bit of a frame, release it, then send 5A -> `ps2_key` is 0 during reset, and the next event is {1,1,0,5A}.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state encoding and Set-2 special scan codes for ps2_key_rx
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_E1     = 8'hE1;
  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam logic [7:0] CODE_AA     = 8'hAA;
  localparam logic [7:0] CODE_EE     = 8'hEE;
  localparam logic [7:0] CODE_FA     = 8'hFA;
  localparam logic [7:0] CODE_FE     = 8'hFE;
  localparam logic [7:0] CODE_00     = 8'h00;
  localparam logic [7:0] CODE_FF     = 8'hFF;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;

  // Keyboard status/ack bytes that never map to a key
  function automatic logic is_status_code(input logic [7:0] b);
    return (b == CODE_00) || (b == CODE_AA) || (b == CODE_EE) ||
           (b == CODE_FA) || (b == CODE_FE) || (b == CODE_FF);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchroniser, clock glitch filter and falling-edge strobe
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic level,
  output logic fall,
  output logic data
);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       level_d;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      level     <= 1'b1;
      level_d   <= 1'b1;
      fall      <= 1'b0;
      cnt       <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      level_d   <= level;
      fall      <= level_d & ~level;
      // level only moves after FILTER_LEN consecutive disagreeing samples
      if (clk_sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == 8'(FILTER_LEN - 1)) begin
        level <= clk_sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign data = data_sync[1];

endmodule

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard receiver producing toggle-strobed key events for hid
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 12000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic clk_level, fall, data, sample;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .level    (clk_level),
    .fall     (fall),
    .data     (data)
  );

  assign sample = fall & ~clk_level;

  ps2_state_t      state, state_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            par_ok, par_ok_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic [2:0]      skip, skip_nxt;
  logic            ext, ext_nxt, rel, rel_nxt;
  logic [10:0]     key_nxt;
  logic            err_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_ok  <= 1'b0;
      to_cnt  <= '0;
      skip    <= '0;
      ext     <= 1'b0;
      rel     <= 1'b0;
      ps2_key <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par_ok  <= par_ok_nxt;
      to_cnt  <= to_cnt_nxt;
      skip    <= skip_nxt;
      ext     <= ext_nxt;
      rel     <= rel_nxt;
      ps2_key <= key_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_ok_nxt  = par_ok;
    to_cnt_nxt  = to_cnt;
    skip_nxt    = skip;
    ext_nxt     = ext;
    rel_nxt     = rel;
    key_nxt     = ps2_key;
    err_nxt     = 1'b0;

    // A sampled bit takes precedence over a timeout landing in the same cycle
    if (sample) begin
      to_cnt_nxt = '0;
      case (state)
        ST_IDLE: begin
          if (!data) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end
        end
        ST_DATA: begin
          shreg_nxt   = {data, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_nxt = ^{shreg, data};
          state_nxt  = ST_STOP;
        end
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (data && par_ok) begin
            if (skip != 3'd0) begin
              skip_nxt = skip - 3'd1;
            end else if (shreg == CODE_E1) begin
              skip_nxt = 3'd7;
            end else if (shreg == CODE_E0) begin
              ext_nxt = 1'b1;
            end else if (shreg == CODE_F0) begin
              rel_nxt = 1'b1;
            end else if (is_status_code(shreg) ||
                         (ext && (shreg == CODE_LSHIFT || shreg == CODE_RSHIFT))) begin
              ext_nxt = 1'b0;
              rel_nxt = 1'b0;
            end else begin
              key_nxt = {~ps2_key[10], ~rel, ext, shreg};
              ext_nxt = 1'b0;
              rel_nxt = 1'b0;
            end
          end else begin
            err_nxt  = 1'b1;
            ext_nxt  = 1'b0;
            rel_nxt  = 1'b0;
            skip_nxt = '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        state_nxt  = ST_IDLE;
        to_cnt_nxt = '0;
        err_nxt    = 1'b1;
        ext_nxt    = 1'b0;
        rel_nxt    = 1'b0;
        skip_nxt   = '0;
      end else begin
        to_cnt_nxt = to_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - randomized scoreboard bench for ps2_key_rx
module tb_ps2_key_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 12000;
  localparam int HALF        = 30;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        err;

  ps2_key_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [9:0] key;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   m_skip = 0;
  bit   m_ext = 0, m_rel = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decoding of one received byte into the expected event stream
  task automatic model_byte(input logic [7:0] b, input bit bad, input int at);
    if (bad) begin
      sb.push_back('{1'b1, 10'h0, at});
      m_skip = 0; m_ext = 0; m_rel = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF} ||
                 (m_ext && (b == 8'h12 || b == 8'h59))) begin
      m_ext = 0; m_rel = 0;
    end else begin
      sb.push_back('{1'b0, {~m_rel, m_ext, b}, at});
      m_ext = 0; m_rel = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                            input bit glitch, input int nbits, output int t_last);
    logic [10:0] fr;
    int w;
    fr = {~bad_stop, ~(^b) ^ flip_par, b, 1'b0};
    t_last = 0;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      ps2_data = fr[i];
      repeat (HALF / 2) @(posedge clk);
      if (glitch) begin
        w = $urandom_range(FILTER_LEN - 2, 1);
        #1 ps2_clk = 1'b0;
        repeat (w) @(posedge clk);
        #1 ps2_clk = 1'b1;
      end
      repeat (HALF / 3) @(posedge clk);
      #1 ps2_clk = 1'b0;
      t_last = cyc;
      if (i == 10) model_byte(b, flip_par | bad_stop, t_last + FILTER_LEN + 4);
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    @(posedge clk); #1;
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit glitch);
    int t;
    send_frame(b, 1'b0, 1'b0, glitch, 11, t);
  endtask

  bit   exp_tgl = 0;
  logic [10:0] prev_key = '0;
  exp_t e;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_key = ps2_key;
      exp_tgl  = 0;
    end else begin
      if (err) begin
        if (sb.size() == 0) check("unexpected_err", 32'(err), 32'd0);
        else begin
          e = sb.pop_front();
          check("err_kind", 32'(e.is_err), 32'd1);
          check("err_cycle", cyc, e.cyc);
        end
      end
      if (ps2_key !== prev_key) begin
        if (sb.size() == 0) check("unexpected_key", 32'(ps2_key), 32'(prev_key));
        else begin
          e = sb.pop_front();
          exp_tgl = ~exp_tgl;
          check("key_kind", 32'(e.is_err), 32'd0);
          check("key_value", 32'(ps2_key), 32'({exp_tgl, e.key}));
          check("key_cycle", cyc, e.cyc);
        end
        prev_key = ps2_key;
      end
    end
  end

  initial begin
    int t;
    logic tb10;
    logic [7:0] rb;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_key", 32'(ps2_key), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);

    send(8'h1C, 1'b0);
    check("first_1c", 32'(ps2_key), 32'h61C);

    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    check("ext_break_75", 32'(ps2_key), 32'h175);

    tb10 = ps2_key[10];
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 11, t);
    send(8'h1C, 1'b0);
    check("after_parity_err", 32'(ps2_key), 32'({~tb10, 1'b1, 1'b0, 8'h1C}));

    send_frame(8'h3B, 1'b0, 1'b0, 1'b0, 5, t);
    sb.push_back('{1'b1, 10'h0, t + FILTER_LEN + 4 + TIMEOUT_CYC});
    m_skip = 0; m_ext = 0; m_rel = 0;
    repeat (TIMEOUT_CYC + 10) @(posedge clk);
    send(8'h29, 1'b0);
    check("after_timeout_29", 32'(ps2_key[9:0]), 32'h229);

    tb10 = ps2_key[10];
    foreach (rb[i]) rb[i] = 1'b0;
    send(8'hE1, 1'b1); send(8'h14, 1'b1); send(8'h77, 1'b1); send(8'hE1, 1'b1);
    send(8'hF0, 1'b1); send(8'h14, 1'b1); send(8'hF0, 1'b1); send(8'h77, 1'b1);
    send(8'hE0, 1'b1); send(8'h12, 1'b1); send(8'hAA, 1'b1); send(8'h16, 1'b1);
    check("pause_then_16", 32'(ps2_key), 32'({~tb10, 1'b1, 1'b0, 8'h16}));

    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom);
      send_frame(rb, ($urandom_range(7, 0) == 0), ($urandom_range(9, 0) == 0),
                 1'($urandom), 11, t);
    end

    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 6, t);
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    check("midframe_reset_key", 32'(ps2_key), 32'd0);
    check("midframe_reset_err", 32'(err), 32'd0);
    sb.delete();
    m_skip = 0; m_ext = 0; m_rel = 0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    send(8'h5A, 1'b0);
    check("post_reset_5a", 32'(ps2_key), 32'h65A);

    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
